// File: rtl/addatone_pkg.sv
// Shared types and widths for the additive-synthesis chain (sequencer, sine ROM, adder).
package addatone_pkg;

  localparam int DEFAULT_DIVISOR_BITS = 11;
  localparam int SAMPLE_BITS          = 16;
  localparam int ACC_BITS             = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOOKUP = 3'd2,
    ISSUE  = 3'd3,
    SETTLE = 3'd4,
    WAIT   = 3'd5,
    FINISH = 3'd6
  } state_t;

endpackage

// File: rtl/sine_lut.sv
// Registered sine ROM: one full cycle over 2**LUT_ADDR_BITS entries, 16-bit signed, 1-cycle read latency.
// Each half-cycle is a parabola u*(H-u) scaled to peak at 32767.
module sine_lut
  import addatone_pkg::*;
#(
  parameter int LUT_ADDR_BITS = 10
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_En,
  input  logic [LUT_ADDR_BITS-1:0]      i_Addr,
  output logic signed [SAMPLE_BITS-1:0] o_Data
);

  localparam logic [LUT_ADDR_BITS-1:0] HALF_TURN  = {1'b1, {(LUT_ADDR_BITS-1){1'b0}}};
  localparam int                       PEAK_SHIFT = 2*LUT_ADDR_BITS - 4;
  localparam logic [SAMPLE_BITS-1:0]   PEAK       = 16'h7FFF;

  logic signed [SAMPLE_BITS-1:0] r_data;

  function automatic logic signed [SAMPLE_BITS-1:0] sine_at(input logic [LUT_ADDR_BITS-1:0] addr);
    logic [LUT_ADDR_BITS-1:0] pos;
    logic [LUT_ADDR_BITS-1:0] span;
    logic [63:0]              mag;
    logic [SAMPLE_BITS-1:0]   clipped;
    pos     = {1'b0, addr[LUT_ADDR_BITS-2:0]};
    span    = HALF_TURN - pos;
    mag     = ((64'(pos) * 64'(span)) << (SAMPLE_BITS-1)) >> PEAK_SHIFT;
    clipped = (mag > 64'(PEAK)) ? PEAK : mag[SAMPLE_BITS-1:0];
    sine_at = addr[LUT_ADDR_BITS-1] ? -$signed(clipped) : $signed(clipped);
  endfunction

  // ROM read register; holds its value while the sequencer is not looking up.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_data <= {SAMPLE_BITS{1'b0}};
    end else if (i_En) begin
      r_data <= sine_at(i_Addr);
    end else begin
      r_data <= r_data;
    end
  end

  assign o_Data = r_data;

endmodule

// File: rtl/harmonic_sequencer.sv
// Harmonic sequencer: on each sample tick clears the adder, issues one scaled-add per harmonic, publishes the mix.
// Build option HARMONIC_SATURATE_EN: clamp the finished mix to 16-bit range instead of wrapping.
module harmonic_sequencer
  import addatone_pkg::*;
#(
  parameter int DIVISOR_BITS  = DEFAULT_DIVISOR_BITS,
  parameter int HARM_BITS     = 6,
  parameter int PHASE_BITS    = 32,
  parameter int LUT_ADDR_BITS = 10,
  parameter int OUT_SHIFT     = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_Sample_Tick,
  input  logic [PHASE_BITS-1:0]         i_Base_Increment,
  input  logic [HARM_BITS-1:0]          i_Harmonic_Count,
  input  logic [DIVISOR_BITS-1:0]       i_Level_Start,
  input  logic [DIVISOR_BITS-1:0]       i_Level_Decay,
  output logic                          o_Adder_Clear,
  output logic                          o_Adder_Start,
  output logic [DIVISOR_BITS-1:0]       o_Multiple,
  output logic signed [SAMPLE_BITS-1:0] o_Sample,
  input  logic                          i_Adder_Done,
  input  logic signed [ACC_BITS-1:0]    i_Accumulator,
  output logic signed [SAMPLE_BITS-1:0] o_Mix,
  output logic                          o_Mix_Valid,
  output logic                          o_Overrun
);

  localparam logic [HARM_BITS-1:0] HARM_ONE = {{(HARM_BITS-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next_state;

  logic [PHASE_BITS-1:0]         r_fund_phase;
  logic [PHASE_BITS-1:0]         r_h_phase;
  logic [PHASE_BITS-1:0]         r_h_inc;
  logic [PHASE_BITS-1:0]         r_base_inc;
  logic [DIVISOR_BITS-1:0]       r_level;
  logic [DIVISOR_BITS-1:0]       r_decay;
  logic [DIVISOR_BITS-1:0]       r_multiple;
  logic [HARM_BITS-1:0]          r_n;
  logic [HARM_BITS-1:0]          r_count;
  logic                          r_adder_clear;
  logic                          r_adder_start;
  logic                          r_mix_valid;
  logic                          r_overrun;
  logic signed [SAMPLE_BITS-1:0] r_mix;

  logic [PHASE_BITS-1:0]         w_fund_next;
  logic [PHASE_BITS:0]           w_inc_sum;
  logic [DIVISOR_BITS-1:0]       w_level_next;
  logic                          w_nyquist;
  logic                          w_last;
  logic                          w_start_seq;
  logic                          w_step;
  logic                          w_lut_en;
  logic signed [SAMPLE_BITS-1:0] w_lut_data;
  logic signed [SAMPLE_BITS-1:0] w_mix;

  assign w_start_seq  = (r_state == IDLE) && i_Sample_Tick;
  assign w_step       = (r_state == WAIT) && i_Adder_Done;
  assign w_fund_next  = r_fund_phase + i_Base_Increment;
  // The carry bit counts as crossing Nyquist, so a wrapped h_inc never looks small.
  assign w_inc_sum    = {1'b0, r_h_inc} + {1'b0, r_base_inc};
  assign w_nyquist    = w_inc_sum[PHASE_BITS] | w_inc_sum[PHASE_BITS-1];
  assign w_level_next = DIVISOR_BITS'(((2*DIVISOR_BITS)'(r_level) * (2*DIVISOR_BITS)'(r_decay)) >> DIVISOR_BITS);
  assign w_last       = (r_n == r_count) | w_nyquist | (w_level_next == {DIVISOR_BITS{1'b0}});
  assign w_lut_en     = (r_state == LOOKUP);

`ifdef HARMONIC_SATURATE_EN
  localparam logic signed [ACC_BITS-1:0] MIX_MAX = 32'sd32767;
  localparam logic signed [ACC_BITS-1:0] MIX_MIN = -32'sd32768;

  logic signed [ACC_BITS-1:0] w_shifted;
  assign w_shifted = i_Accumulator >>> OUT_SHIFT;

  // Clamp the scaled accumulator into the signed 16-bit output range.
  always_comb begin
    w_mix = {SAMPLE_BITS{1'b0}};
    if (w_shifted > MIX_MAX) begin
      w_mix = 16'sh7FFF;
    end else if (w_shifted < MIX_MIN) begin
      w_mix = 16'sh8000;
    end else begin
      w_mix = $signed(w_shifted[SAMPLE_BITS-1:0]);
    end
  end
`else
  assign w_mix = SAMPLE_BITS'(i_Accumulator >>> OUT_SHIFT);
`endif

  sine_lut #(
    .LUT_ADDR_BITS (LUT_ADDR_BITS)
  ) u_sine_lut (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_En      (w_lut_en),
    .i_Addr    (r_h_phase[PHASE_BITS-1 -: LUT_ADDR_BITS]),
    .o_Data    (w_lut_data)
  );

  // State register.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the adder's Done is ignored in ISSUE/SETTLE while it is still stale.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = i_Sample_Tick ? CLEAR : IDLE;
      CLEAR:   w_next_state = (r_count == {HARM_BITS{1'b0}}) ? FINISH : LOOKUP;
      LOOKUP:  w_next_state = ISSUE;
      ISSUE:   w_next_state = SETTLE;
      SETTLE:  w_next_state = WAIT;
      WAIT: begin
        if (i_Adder_Done) begin
          w_next_state = w_last ? FINISH : LOOKUP;
        end else begin
          w_next_state = WAIT;
        end
      end
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Phase accumulators, harmonic counter and level roll-off.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_fund_phase <= {PHASE_BITS{1'b0}};
      r_h_phase    <= {PHASE_BITS{1'b0}};
      r_h_inc      <= {PHASE_BITS{1'b0}};
      r_base_inc   <= {PHASE_BITS{1'b0}};
      r_level      <= {DIVISOR_BITS{1'b0}};
      r_decay      <= {DIVISOR_BITS{1'b0}};
      r_count      <= {HARM_BITS{1'b0}};
      r_n          <= {HARM_BITS{1'b0}};
    end else if (w_start_seq) begin
      r_fund_phase <= w_fund_next;
      r_h_phase    <= w_fund_next;
      r_h_inc      <= i_Base_Increment;
      r_base_inc   <= i_Base_Increment;
      r_level      <= i_Level_Start;
      r_decay      <= i_Level_Decay;
      r_count      <= i_Harmonic_Count;
      r_n          <= HARM_ONE;
    end else if (w_step) begin
      r_n          <= r_n + HARM_ONE;
      r_h_phase    <= r_h_phase + r_fund_phase;
      r_h_inc      <= w_inc_sum[PHASE_BITS-1:0];
      r_level      <= w_level_next;
    end
  end

  // Output registers, decoded from the state being entered so pulses align with their state.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_adder_clear <= 1'b0;
      r_adder_start <= 1'b0;
      r_multiple    <= {DIVISOR_BITS{1'b0}};
      r_mix_valid   <= 1'b0;
      r_mix         <= {SAMPLE_BITS{1'b0}};
      r_overrun     <= 1'b0;
    end else begin
      r_adder_clear <= (w_next_state == CLEAR);
      r_adder_start <= (w_next_state == ISSUE);
      r_multiple    <= (w_next_state == ISSUE) ? r_level : r_multiple;
      r_mix_valid   <= (r_state == FINISH);
      r_mix         <= (r_state == FINISH) ? w_mix : r_mix;
      r_overrun     <= r_overrun | (i_Sample_Tick && (r_state != IDLE));
    end
  end

  assign o_Adder_Clear = r_adder_clear;
  assign o_Adder_Start = r_adder_start;
  assign o_Multiple    = r_multiple;
  assign o_Sample      = w_lut_data;
  assign o_Mix         = r_mix;
  assign o_Mix_Valid   = r_mix_valid;
  assign o_Overrun     = r_overrun;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed bench for harmonic_sequencer with a minimal adder handshake model.
module tb_harmonic_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [31:0] base_inc;
  logic [5:0]  hcount;
  logic [10:0] lvl_start;
  logic [10:0] lvl_decay;
  logic        done = 1'b1;
  logic [31:0] acc;
  logic        adder_clear;
  logic        adder_start;
  logic [10:0] multiple;
  logic [15:0] sample;
  logic [15:0] mix;
  logic        mix_valid;
  logic        overrun;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          clear_cnt = 0;
  int          start_cnt = 0;
  int          mix_cnt = 0;
  int          clear_cyc = 0;
  int          last_start_cyc = 0;
  int          valid_cyc = 0;
  int          tick_cyc = 0;
  int          add_wait = 0;
  logic        hold_done = 1'b0;
  logic [15:0] last_mix = 16'h0000;
  logic [15:0] samp_q[$];
  logic [10:0] mult_q[$];
  int          sb, cb, mb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  harmonic_sequencer dut (
    .i_Clock          (clk),
    .i_Reset_n        (rst_n),
    .i_Sample_Tick    (tick),
    .i_Base_Increment (base_inc),
    .i_Harmonic_Count (hcount),
    .i_Level_Start    (lvl_start),
    .i_Level_Decay    (lvl_decay),
    .o_Adder_Clear    (adder_clear),
    .o_Adder_Start    (adder_start),
    .o_Multiple       (multiple),
    .o_Sample         (sample),
    .i_Adder_Done     (done),
    .i_Accumulator    (acc),
    .o_Mix            (mix),
    .o_Mix_Valid      (mix_valid),
    .o_Overrun        (overrun)
  );

  // Adder model (Done drops after Start, returns one cycle later) and output monitor.
  always @(negedge clk) begin
    if (adder_clear) begin
      clear_cnt++;
      clear_cyc = cyc;
    end
    if (adder_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      samp_q.push_back(sample);
      mult_q.push_back(multiple);
      done = 1'b0;
      add_wait = 0;
    end else if (!done && !hold_done) begin
      if (add_wait == 0) done = 1'b1;
      else add_wait--;
    end
    if (mix_valid) begin
      mix_cnt++;
      valid_cyc = cyc;
      last_mix = mix;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] samp_at(input int idx);
    if (idx < samp_q.size()) return samp_q[idx];
    else return 16'hDEAD;
  endfunction

  function automatic logic [10:0] mult_at(input int idx);
    if (idx < mult_q.size()) return mult_q[idx];
    else return 11'h7FF;
  endfunction

  task automatic run_tick();
    tick_cyc = cyc;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_mix(input int target, input int budget);
    int k = 0;
    while (mix_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (mix_cnt < target) check_eq("mix_timeout", 64'(mix_cnt), 64'(target));
    @(negedge clk);
  endtask

  task automatic snap();
    sb = start_cnt;
    cb = clear_cnt;
    mb = mix_cnt;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; base_inc = 32'h0; hcount = 6'd0;
    lvl_start = 11'd0; lvl_decay = 11'd0; acc = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", 64'({adder_clear, adder_start, mix_valid, overrun}), 64'h0);
    check_eq("rst_mix", 64'(mix), 64'h0);
    check_eq("rst_sample", 64'(sample), 64'h0);
    check_eq("rst_mult", 64'(multiple), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single harmonic: phase 2**24 -> LUT address 4 -> 1016.
    base_inc = 32'h0100_0000; hcount = 6'd1; lvl_start = 11'd1024; lvl_decay = 11'd1024;
    acc = 32'h0001_2340;
    snap(); run_tick(); wait_mix(mb + 1, 60);
    check_eq("a_starts", 64'(start_cnt - sb), 64'd1);
    check_eq("a_clears", 64'(clear_cnt - cb), 64'd1);
    check_eq("a_clear_lat", 64'(clear_cyc - tick_cyc), 64'd1);
    check_eq("a_start_lat", 64'(last_start_cyc - tick_cyc), 64'd3);
    check_eq("a_valid_lat", 64'(valid_cyc - tick_cyc), 64'd7);
    check_eq("a_sample", 64'(samp_at(sb)), 64'd1016);
    check_eq("a_mult", 64'(mult_at(sb)), 64'd1024);
    check_eq("a_mix", 64'(last_mix), 64'h1234);

    // Three harmonics, fundamental now 2**25: addresses 8/16/24, levels halve.
    hcount = 6'd3; acc = 32'hFFFF_0000;
    snap(); run_tick(); wait_mix(mb + 1, 100);
    check_eq("b_starts", 64'(start_cnt - sb), 64'd3);
    check_eq("b_s1", 64'(samp_at(sb)), 64'd2016);
    check_eq("b_s2", 64'(samp_at(sb + 1)), 64'd3968);
    check_eq("b_s3", 64'(samp_at(sb + 2)), 64'd5856);
    check_eq("b_m1", 64'(mult_at(sb)), 64'd1024);
    check_eq("b_m2", 64'(mult_at(sb + 1)), 64'd512);
    check_eq("b_m3", 64'(mult_at(sb + 2)), 64'd256);
    check_eq("b_valid_lat", 64'(valid_cyc - tick_cyc), 64'd15);
    check_eq("b_mix", 64'(last_mix), 64'hF000);

    // Zero decay: level hits 0 after harmonic 1. Fundamental 3*2**24 -> address 12.
    hcount = 6'd8; lvl_decay = 11'd0;
    snap(); run_tick(); wait_mix(mb + 1, 100);
    check_eq("c_starts", 64'(start_cnt - sb), 64'd1);
    check_eq("c_mult", 64'(mult_at(sb)), 64'd1024);
    check_eq("c_sample", 64'(samp_at(sb)), 64'd3000);
    check_eq("c_valid_lat", 64'(valid_cyc - tick_cyc), 64'd7);

    // Nyquist: increment 2**28 stops after harmonic 7; address of harmonic 1 is 76.
    hcount = 6'd63; base_inc = 32'h1000_0000; lvl_decay = 11'd2047;
    snap(); run_tick(); wait_mix(mb + 1, 200);
    check_eq("d_starts", 64'(start_cnt - sb), 64'd7);
    check_eq("d_valid_lat", 64'(valid_cyc - tick_cyc), 64'd31);
    check_eq("d_sample", 64'(samp_at(sb)), 64'd16568);
    check_eq("d_m2", 64'(mult_at(sb + 1)), 64'd1023);
    check_eq("d_m7", 64'(mult_at(sb + 6)), 64'd1018);

    // Tick while busy: flagged, ignored, phase not advanced.
    pulse_reset(); @(negedge clk);
    check_eq("e_overrun_clr", 64'(overrun), 64'd0);
    base_inc = 32'h0100_0000; hcount = 6'd2; lvl_decay = 11'd1024;
    snap(); run_tick();
    repeat (2) @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check_eq("e_overrun", 64'(overrun), 64'd1);
    wait_mix(mb + 1, 100);
    check_eq("e_starts", 64'(start_cnt - sb), 64'd2);
    check_eq("e_s2", 64'(samp_at(sb + 1)), 64'd2016);
    check_eq("e_valid_lat", 64'(valid_cyc - tick_cyc), 64'd11);
    hcount = 6'd1;
    snap(); run_tick(); wait_mix(mb + 1, 60);
    check_eq("e_fund_kept", 64'(samp_at(sb)), 64'd2016);
    check_eq("e_overrun_sticky", 64'(overrun), 64'd1);

    // Tick in the cycle FINISH exits is also an overrun.
    pulse_reset(); @(negedge clk);
    snap(); run_tick();
    repeat (5) @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("f_overrun", 64'(overrun), 64'd1);
    check_eq("f_clears", 64'(clear_cnt - cb), 64'd1);
    check_eq("f_mixes", 64'(mix_cnt - mb), 64'd1);

    // Reset while stuck in WAIT, then a clean restart.
    pulse_reset(); @(negedge clk);
    hold_done = 1'b1;
    snap(); run_tick();
    repeat (8) @(negedge clk);
    check_eq("g_stuck", 64'(mix_cnt - mb), 64'd0);
    check_eq("g_sample_held", 64'(sample), 64'd1016);
    pulse_reset();
    check_eq("g_rst_sample", 64'(sample), 64'd0);
    check_eq("g_rst_mult", 64'(multiple), 64'd0);
    check_eq("g_rst_ctrl", 64'({adder_clear, adder_start, mix_valid}), 64'd0);
    hold_done = 1'b0;
    @(negedge clk);
    snap(); run_tick(); wait_mix(mb + 1, 60);
    check_eq("g_clear_lat", 64'(clear_cyc - tick_cyc), 64'd1);
    check_eq("g_valid_lat", 64'(valid_cyc - tick_cyc), 64'd7);
    check_eq("g_starts", 64'(start_cnt - sb), 64'd1);

    // Silence path and output range handling.
    hcount = 6'd0; acc = 32'h0010_0000;
    snap(); run_tick(); wait_mix(mb + 1, 30);
    check_eq("h_starts", 64'(start_cnt - sb), 64'd0);
    check_eq("h_clears", 64'(clear_cnt - cb), 64'd1);
    check_eq("h_valid_lat", 64'(valid_cyc - tick_cyc), 64'd3);
`ifdef HARMONIC_SATURATE_EN
    check_eq("h_mix_pos", 64'(last_mix), 64'h7FFF);
`else
    check_eq("h_mix_pos", 64'(last_mix), 64'h0000);
`endif
    acc = 32'h8000_0000;
    snap(); run_tick(); wait_mix(mb + 1, 30);
`ifdef HARMONIC_SATURATE_EN
    check_eq("h_mix_neg", 64'(last_mix), 64'h8000);
`else
    check_eq("h_mix_neg", 64'(last_mix), 64'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
